// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the programmable timer.
//   - register addresses on the 2-bit I/O select
//   - overflow/reload state encoding
//   - TAC tap-select table mapping tac[1:0] to a divider bit
package timer_ctrl_pkg;

   localparam logic [1:0] ADDR_DIV  = 2'd0;
   localparam logic [1:0] ADDR_TIMA = 2'd1;
   localparam logic [1:0] ADDR_TMA  = 2'd2;
   localparam logic [1:0] ADDR_TAC  = 2'd3;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StOvf    = 2'd1,
      StReload = 2'd2
   } timer_state_e;

   // Divider bit watched by TIMA for each TAC rate select.
   function automatic logic [3:0] tac_tap(input logic [1:0] sel);
      logic [3:0] bit_idx;
      case (sel)
         2'b00:   bit_idx = 4'd9;
         2'b01:   bit_idx = 4'd3;
         2'b10:   bit_idx = 4'd5;
         default: bit_idx = 4'd7;
      endcase
      return bit_idx;
   endfunction

endpackage

// File: rtl/timer_ctrl_div.sv
// Free-running 16-bit divider with synchronous clear, plus the TAC-selected,
// enable-gated tap that feeds the TIMA edge detector.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   clr     in   synchronous clear (DIV register write)
//   tac     in   [2]=enable, [1:0]=tap select
//   div_hi  out  upper divider byte, as seen by DIV reads
//   sig     out  tac[2] & divider[selected tap]
module timer_ctrl_div
   import timer_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic [2:0] tac,
   output logic [7:0] div_hi,
   output logic       sig
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = clr ? 16'h0000 : cnt_q + 16'h0001;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign div_hi = cnt_q[15:8];
   assign sig    = tac[2] & cnt_q[tac_tap(tac[1:0])];

endmodule

// File: rtl/timer_ctrl.sv
// CPU-visible programmable timer: DIV, TIMA, TMA and TAC byte registers.
// TIMA counts falling edges of a TAC-selected divider tap. On overflow TIMA
// reads 00 for RELOAD_DELAY clocks, then reloads from TMA and pulses irq.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   addr     in   register select: 0=DIV 1=TIMA 2=TMA 3=TAC
//   wr_en    in   write strobe, sampled on the rising edge
//   wr_data  in   write data
//   rd_data  out  combinational read of the selected register
//   irq      out  one-clock timer interrupt pulse
module timer_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int unsigned RELOAD_DELAY = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] addr,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       irq
);

   localparam int unsigned     DlyW    = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
   localparam logic [DlyW-1:0] DlyInit = DlyW'(RELOAD_DELAY - 1);

   timer_state_e    state_q, state_d;
   logic [DlyW-1:0] dly_q, dly_d;
   logic [7:0]      tima_q, tima_d;
   logic [7:0]      tma_q, tma_d;
   logic [2:0]      tac_q, tac_d;
   logic            irq_q, irq_d;
   logic            sig_q;

   logic       sig;
   logic       tick;
   logic [7:0] div_hi;
   logic       wr_div, wr_tima, wr_tma, wr_tac;

   assign wr_div  = wr_en && (addr == ADDR_DIV);
   assign wr_tima = wr_en && (addr == ADDR_TIMA);
   assign wr_tma  = wr_en && (addr == ADDR_TMA);
   assign wr_tac  = wr_en && (addr == ADDR_TAC);

   timer_ctrl_div u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (wr_div),
      .tac    (tac_q),
      .div_hi (div_hi),
      .sig    (sig)
   );

   // Falling edge of the gated tap. A DIV clear, tap change or disable while
   // the tap is high also counts as an edge.
   assign tick = sig_q & ~sig;

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      tima_d  = tima_q;
      tma_d   = wr_tma ? wr_data : tma_q;
      tac_d   = wr_tac ? wr_data[2:0] : tac_q;
      irq_d   = 1'b0;

      case (state_q)
         StRun: begin
            // A TIMA write beats a coincident tick.
            if (wr_tima) begin
               tima_d = wr_data;
            end else if (tick) begin
               if (tima_q == 8'hFF) begin
                  tima_d  = 8'h00;
                  dly_d   = DlyInit;
                  state_d = StOvf;
               end else begin
                  tima_d = tima_q + 8'h01;
               end
            end
         end
         StOvf: begin
            if (wr_tima) begin
               // CPU write cancels the pending reload and interrupt.
               tima_d  = wr_data;
               state_d = StRun;
            end else if (dly_q == '0) begin
               // Reload uses TMA including a same-cycle TMA write.
               tima_d  = tma_d;
               irq_d   = 1'b1;
               state_d = StReload;
            end else begin
               dly_d = dly_q - DlyW'(1);
            end
         end
         StReload: begin
            // TIMA already holds TMA; a TMA write here lands in both.
            if (wr_tma) begin
               tima_d = wr_data;
            end
            state_d = StRun;
         end
         default: begin
            state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         dly_q   <= '0;
         tima_q  <= 8'h00;
         tma_q   <= 8'h00;
         tac_q   <= 3'b000;
         irq_q   <= 1'b0;
         sig_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         tima_q  <= tima_d;
         tma_q   <= tma_d;
         tac_q   <= tac_d;
         irq_q   <= irq_d;
         sig_q   <= sig;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (addr)
         ADDR_DIV:  rd_data = div_hi;
         ADDR_TIMA: rd_data = tima_q;
         ADDR_TMA:  rd_data = tma_q;
         default:   rd_data = {5'b11111, tac_q};
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_timer_ctrl;

   localparam int RD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] addr = 2'd0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] rd_data;
   logic       irq;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit started = 1'b0;

   timer_ctrl #(
      .RELOAD_DELAY (RD)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .addr    (addr),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .irq     (irq)
   );

   initial forever #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [15:0] m_div;
   logic [7:0]  m_tima, m_tma;
   logic [2:0]  m_tac;
   logic        m_sigprev, m_irq, m_in_reload;
   int          m_since;       // zero-cycles elapsed since overflow, -1 when none pending
   int          tap_tbl [4] = '{9, 3, 5, 7};

   task automatic model_reset();
      m_div = 16'h0000; m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
      m_sigprev = 1'b0; m_irq = 1'b0; m_in_reload = 1'b0; m_since = -1;
   endtask

   task automatic model_step();
      logic sig, tick, w_div, w_tima, w_tma, w_tac, n_irq;
      logic [7:0] n_tma;
      sig    = m_tac[2] & m_div[tap_tbl[m_tac[1:0]]];
      tick   = m_sigprev & ~sig;
      w_div  = wr_en && addr == 2'd0;
      w_tima = wr_en && addr == 2'd1;
      w_tma  = wr_en && addr == 2'd2;
      w_tac  = wr_en && addr == 2'd3;
      n_tma  = w_tma ? wr_data : m_tma;
      n_irq  = 1'b0;
      if (m_in_reload) begin
         m_in_reload = 1'b0;
         if (w_tma) m_tima = wr_data;
      end else if (m_since >= 0) begin
         if (w_tima) begin
            m_tima  = wr_data;
            m_since = -1;
         end else begin
            m_since++;
            if (m_since == RD) begin
               m_since     = -1;
               m_tima      = n_tma;
               n_irq       = 1'b1;
               m_in_reload = 1'b1;
            end
         end
      end else if (w_tima) begin
         m_tima = wr_data;
      end else if (tick) begin
         if (m_tima == 8'hFF) begin
            m_tima  = 8'h00;
            m_since = 0;
         end else begin
            m_tima = m_tima + 8'd1;
         end
      end
      m_tma = n_tma;
      if (w_tac) m_tac = wr_data[2:0];
      m_div     = w_div ? 16'h0000 : m_div + 16'd1;
      m_sigprev = sig;
      m_irq     = n_irq;
   endtask

   function automatic logic [7:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return m_div[15:8];
         2'd1:    return m_tima;
         2'd2:    return m_tma;
         default: return {5'b11111, m_tac};
      endcase
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (started) begin
         check("model rd_data", rd_data, model_read(addr));
         check("model irq", {7'b0, irq}, {7'b0, m_irq});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      addr = a; wr_en = 1'b1; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic expect_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
      addr = a;
      #1;
      check(name, rd_data, exp);
   endtask

   task automatic expect_irq(input string name, input logic exp);
      check(name, {7'b0, irq}, {7'b0, exp});
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wr_en = 1'b0; addr = 2'd0; wr_data = 8'h00;
      step();
      step();
      rst_n = 1'b1;
      cyc = 0;
   endtask

   // TMA=42, TIMA=FE, TAC=101 on cycles 1..3: ticks land on cycles 17 and 33.
   task automatic ovf_setup();
      do_reset();
      wr(2'd2, 8'h42);
      wr(2'd1, 8'hFE);
      wr(2'd3, 8'h05);
   endtask

   initial begin
      // 1: count rate and DIV
      do_reset();
      started = 1'b1;
      check("reset irq", {7'b0, irq}, 8'h00);
      expect_reg("reset TAC", 2'd3, 8'hF8);
      expect_reg("reset TIMA", 2'd1, 8'h00);
      wr(2'd3, 8'h05);
      addr = 2'd0;
      run_to(255);
      expect_reg("DIV@255", 2'd0, 8'h00);
      run_to(256);
      expect_reg("DIV@256", 2'd0, 8'h01);
      expect_reg("TIMA@256", 2'd1, 8'h0F);
      run_to(257);
      expect_reg("TIMA@257", 2'd1, 8'h10);
      run_to(272);
      expect_reg("TIMA@272", 2'd1, 8'h10);
      run_to(273);
      expect_reg("TIMA@273", 2'd1, 8'h11);

      // 2: overflow, delay, reload, irq
      ovf_setup();
      run_to(32);
      expect_reg("ovf TIMA pre", 2'd1, 8'hFF);
      for (int n = 33; n <= 36; n++) begin
         run_to(n);
         expect_reg("ovf TIMA zero", 2'd1, 8'h00);
         expect_irq("ovf irq low", 1'b0);
      end
      run_to(37);
      expect_reg("reload TIMA", 2'd1, 8'h42);
      expect_irq("reload irq", 1'b1);
      run_to(38);
      expect_irq("irq one clock", 1'b0);
      expect_reg("post reload TIMA", 2'd1, 8'h42);

      // 3: TIMA write during OVF cancels reload
      ovf_setup();
      run_to(34);
      wr(2'd1, 8'h10);
      expect_reg("cancel TIMA", 2'd1, 8'h10);
      for (int n = 36; n <= 38; n++) begin
         run_to(n);
         expect_reg("cancel TIMA hold", 2'd1, 8'h10);
         expect_irq("cancel irq", 1'b0);
      end

      // 4: TMA write in RELOAD
      ovf_setup();
      run_to(37);
      expect_irq("tma-reload irq", 1'b1);
      wr(2'd2, 8'h77);
      expect_reg("tma-reload TIMA", 2'd1, 8'h77);
      expect_reg("tma-reload TMA", 2'd2, 8'h77);
      expect_irq("tma-reload irq off", 1'b0);
      step();
      expect_irq("tma-reload irq once", 1'b0);

      // 5: DIV write while tap high gives a tick
      do_reset();
      wr(2'd3, 8'h05);
      run_to(8);
      wr(2'd0, 8'hA5);
      expect_reg("divclr DIV", 2'd0, 8'h00);
      expect_reg("divclr TIMA before", 2'd1, 8'h00);
      step();
      expect_reg("divclr TIMA tick", 2'd1, 8'h01);

      // 6: reset mid-OVF
      ovf_setup();
      run_to(34);
      rst_n = 1'b0;
      expect_reg("rst TIMA", 2'd1, 8'h00);
      expect_reg("rst TMA", 2'd2, 8'h00);
      step();
      expect_reg("rst TAC", 2'd3, 8'hF8);
      expect_reg("rst DIV", 2'd0, 8'h00);
      expect_irq("rst irq", 1'b0);
      step();
      rst_n = 1'b1;
      cyc = 0;
      for (int n = 1; n <= 8; n++) begin
         step();
         expect_irq("rst irq stays low", 1'b0);
      end
      expect_reg("rst TIMA after", 2'd1, 8'h00);

      // randomized run against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         addr    = 2'($urandom_range(0, 3));
         wr_en   = ($urandom_range(0, 7) == 0);
         wr_data = 8'($urandom);
         if (addr == 2'd0 && $urandom_range(0, 3) != 0) wr_en = 1'b0;
         if (addr == 2'd1 && $urandom_range(0, 1) == 0) wr_data = wr_data | 8'hF8;
         if (addr == 2'd3 && $urandom_range(0, 3) != 0) wr_data = {5'b0, 1'b1, wr_data[1:0]};
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            step();
            step();
            rst_n = 1'b1;
         end
         step();
      end
      wr_en = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
